// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single synchronous memory, with lockable bursts capped at MAX_BURST.
// Latency: grant and memory command are combinational from req; read data returns one cycle after grant.
// Backpressure: a requester holds req until it sees gnt; with MEM_ARB_FIXED_PRIO_EN defined, contention in IDLE always favours port 0.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic                  r0_lock,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic                  r1_lock,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r0_gnt,
    output logic                  r1_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [1:0]            state_leds
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Burst counter is 8 bits wide, enough for the largest legal MAX_BURST.
    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    logic [1:0] state_q, state_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       last_winner_q, last_winner_d;
    logic       r0_rvalid_q, r0_rvalid_d;
    logic       r1_rvalid_q, r1_rvalid_d;

    logic       gnt0, gnt1;
    logic       any_gnt;
    logic       win_lock;
    logic       win_we;

    // Grant selection: IDLE arbitrates, OWNn only serves its owner; reset masks all grants.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (r0_req && r1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    gnt0 = 1'b1;
`else
                    // Round robin: the port that did not win last time goes first.
                    if (last_winner_q) begin
                        gnt0 = 1'b1;
                    end else begin
                        gnt1 = 1'b1;
                    end
`endif
                end else begin
                    gnt0 = r0_req;
                    gnt1 = r1_req;
                end
            end
            ST_OWN0: gnt0 = r0_req;
            ST_OWN1: gnt1 = r1_req;
            default: begin
                gnt0 = 1'b0;
                gnt1 = 1'b0;
            end
        endcase
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign any_gnt  = gnt0 | gnt1;
    assign win_lock = gnt1 ? r1_lock : r0_lock;
    assign win_we   = gnt1 ? r1_we : r0_we;

    // Next state, burst accounting and round-robin history.
    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        last_winner_d = last_winner_q;
        if (any_gnt) begin
            last_winner_d = gnt1;
            // The count includes the grant being issued now, so the MAX_BURST-th grant releases.
            burst_cnt_d   = (state_q == ST_IDLE) ? 8'd1 : (burst_cnt_q + 8'd1);
            if (win_lock && (burst_cnt_d < MAX_CNT)) begin
                state_d = gnt1 ? ST_OWN1 : ST_OWN0;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                // Owner idle without a grant: keep ownership only while it still asserts lock.
                ST_OWN0: state_d = r0_lock ? ST_OWN0 : ST_IDLE;
                ST_OWN1: state_d = r1_lock ? ST_OWN1 : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A granted read returns data on the following cycle, when the memory presents it.
    always_comb begin
        r0_rvalid_d = gnt0 & ~r0_we;
        r1_rvalid_d = gnt1 & ~r1_we;
    end

    // State registers; reset leaves last_winner at 1 so port 0 wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            burst_cnt_q   <= 8'd0;
            last_winner_q <= 1'b1;
            r0_rvalid_q   <= 1'b0;
            r1_rvalid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            last_winner_q <= last_winner_d;
            r0_rvalid_q   <= r0_rvalid_d;
            r1_rvalid_q   <= r1_rvalid_d;
        end
    end

    assign r0_gnt     = gnt0;
    assign r1_gnt     = gnt1;
    assign mem_en     = any_gnt;
    assign mem_we     = any_gnt & win_we;
    assign mem_addr   = gnt1 ? r1_addr : r0_addr;
    assign mem_din    = gnt1 ? r1_wdata : r0_wdata;
    assign r0_rvalid  = r0_rvalid_q;
    assign r1_rvalid  = r1_rvalid_q;
    assign r0_rdata   = mem_dout;
    assign r1_rdata   = mem_dout;
    assign state_leds = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       r0_req, r0_we, r0_lock;
    logic [7:0] r0_addr, r0_wdata;
    logic       r1_req, r1_we, r1_lock;
    logic [7:0] r1_addr, r1_wdata;
    logic       r0_gnt, r1_gnt;
    logic       r0_rvalid, r1_rvalid;
    logic [7:0] r0_rdata, r1_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_din, mem_dout;
    logic [1:0] state_leds;

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .state_leds(state_leds)
    );

    typedef struct packed {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] din;
    } g_t;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } r_t;

    g_t gq[$];
    r_t rq[$];
    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:255];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: 1-cycle read latency; reset preloads addr ^ 8'h5A.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected grants / read returns whenever the DUT presents one.
    always @(negedge clk) begin
        g_t ge;
        r_t re;
        if (!rst) begin
            chk("gnt0_without_req", {31'd0, r0_gnt & ~r0_req}, 32'd0);
            chk("gnt1_without_req", {31'd0, r1_gnt & ~r1_req}, 32'd0);
            if (r0_gnt || r1_gnt) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gnt: got r0_gnt=%0b r1_gnt=%0b expected none at %0t",
                             r0_gnt, r1_gnt, $time);
                end else begin
                    ge = gq.pop_front();
                    chk("gnt_onehot", {31'd0, r0_gnt & r1_gnt}, 32'd0);
                    chk("gnt_port", {31'd0, r1_gnt}, {31'd0, ge.port});
                    chk("mem_en", {31'd0, mem_en}, 32'd1);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, ge.we});
                    chk("mem_addr", {24'd0, mem_addr}, {24'd0, ge.addr});
                    chk("mem_din", {24'd0, mem_din}, {24'd0, ge.din});
                end
            end else begin
                chk("idle_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
            end
            if (r0_rvalid || r1_rvalid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got r0_rvalid=%0b r1_rvalid=%0b expected none at %0t",
                             r0_rvalid, r1_rvalid, $time);
                end else begin
                    re = rq.pop_front();
                    chk("rvalid_onehot", {31'd0, r0_rvalid & r1_rvalid}, 32'd0);
                    chk("rvalid_port", {31'd0, r1_rvalid}, {31'd0, re.port});
                    chk("rdata", {24'd0, (r1_rvalid ? r1_rdata : r0_rdata)}, {24'd0, re.data});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach end of stimulus");
        $fatal(1);
    end

    initial begin
        logic w;
        rst = 1'b1;
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 8'h00; r0_wdata = 8'h00;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 8'h00; r1_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        // Requests during reset must be ignored.
        r0_req = 1; r0_addr = 8'h20;
        r1_req = 1; r1_addr = 8'h30;
        @(negedge clk);
        chk("rst_state", {30'd0, state_leds}, 32'd0);
        chk("rst_gnt", {30'd0, r0_gnt, r1_gnt}, 32'd0);
        chk("rst_mem", {30'd0, mem_en, mem_we}, 32'd0);
        chk("rst_rvalid", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both read every cycle, no lock: alternate starting with port 0.
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = (i % 2 == 1);
`endif
            gq.push_back('{port: w, we: 1'b0, addr: (w ? 8'h30 : 8'h20), din: 8'h00});
            rq.push_back('{port: w, data: (w ? 8'h30 : 8'h20) ^ 8'h5A});
            next_cyc();
        end

        // Port 0 write then read back.
        r1_req = 0;
        r0_we = 1; r0_addr = 8'h10; r0_wdata = 8'hA5;
        gq.push_back('{port: 1'b0, we: 1'b1, addr: 8'h10, din: 8'hA5});
        next_cyc();
        r0_we = 0; r0_wdata = 8'h00;
        gq.push_back('{port: 1'b0, we: 1'b0, addr: 8'h10, din: 8'h00});
        rq.push_back('{port: 1'b0, data: 8'hA5});
        next_cyc();
        r0_req = 0;
        @(negedge clk);
        chk("wr_rd_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
        next_cyc();

        // Port 1 locked writes capped at 4, port 0 waiting.
        r1_req = 1; r1_lock = 1; r1_we = 1; r1_addr = 8'h41; r1_wdata = 8'h91;
        gq.push_back('{port: 1'b1, we: 1'b1, addr: 8'h41, din: 8'h91});
        next_cyc();
        r0_req = 1; r0_we = 0; r0_lock = 0; r0_addr = 8'h50; r0_wdata = 8'h00;
        for (int j = 2; j <= 4; j++) begin
            r1_addr = 8'h40 + 8'(j);
            r1_wdata = 8'h90 + 8'(j);
            gq.push_back('{port: 1'b1, we: 1'b1, addr: 8'h40 + 8'(j), din: 8'h90 + 8'(j)});
            @(negedge clk);
            chk("burst_state", {30'd0, state_leds}, 32'd2);
            chk("burst_r0_wait", {31'd0, r0_gnt}, 32'd0);
            next_cyc();
        end
        gq.push_back('{port: 1'b0, we: 1'b0, addr: 8'h50, din: 8'h00});
        rq.push_back('{port: 1'b0, data: 8'h0A});
        @(negedge clk);
        chk("burst_release_state", {30'd0, state_leds}, 32'd0);
        next_cyc();
        r0_req = 0; r1_req = 0; r1_lock = 0; r1_we = 0;
        next_cyc();

        // Port 0 owns, idles with lock held, then drops lock; port 1 then served.
        r0_req = 1; r0_lock = 1; r0_we = 0; r0_addr = 8'h60;
        gq.push_back('{port: 1'b0, we: 1'b0, addr: 8'h60, din: 8'h00});
        rq.push_back('{port: 1'b0, data: 8'h3A});
        next_cyc();
        r0_req = 0; r0_lock = 1;
        r1_req = 1; r1_we = 0; r1_lock = 0; r1_addr = 8'h70; r1_wdata = 8'h00;
        @(negedge clk);
        chk("own0_state", {30'd0, state_leds}, 32'd1);
        chk("own0_r1_wait", {31'd0, r1_gnt}, 32'd0);
        next_cyc();
        r0_lock = 0;
        @(negedge clk);
        chk("own0_hold_state", {30'd0, state_leds}, 32'd1);
        chk("own0_drop_no_gnt", {31'd0, r1_gnt}, 32'd0);
        next_cyc();
        gq.push_back('{port: 1'b1, we: 1'b0, addr: 8'h70, din: 8'h00});
        rq.push_back('{port: 1'b1, data: 8'h2A});
        @(negedge clk);
        chk("own0_released_state", {30'd0, state_leds}, 32'd0);
        next_cyc();
        r1_req = 0;
        next_cyc();

        // Reset in the middle of a port 1 burst, read granted just before.
        r1_req = 1; r1_lock = 1; r1_we = 0; r1_addr = 8'h80;
        gq.push_back('{port: 1'b1, we: 1'b0, addr: 8'h80, din: 8'h00});
        rq.push_back('{port: 1'b1, data: 8'hDA});
        next_cyc();
        r1_addr = 8'h81;
        r0_req = 1; r0_we = 0; r0_lock = 0; r0_addr = 8'h90;
        gq.push_back('{port: 1'b1, we: 1'b0, addr: 8'h81, din: 8'h00});
        @(negedge clk);
        chk("pre_rst_state", {30'd0, state_leds}, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_state", {30'd0, state_leds}, 32'd0);
        chk("async_rst_gnt", {30'd0, r0_gnt, r1_gnt}, 32'd0);
        chk("async_rst_mem", {30'd0, mem_en, mem_we}, 32'd0);
        @(negedge clk);
        chk("rst_kills_rvalid", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r1_lock = 0; r1_addr = 8'h91;
        gq.push_back('{port: 1'b0, we: 1'b0, addr: 8'h90, din: 8'h00});
        rq.push_back('{port: 1'b0, data: 8'hCA});
        @(negedge clk);
        chk("post_rst_state", {30'd0, state_leds}, 32'd0);
        next_cyc();
        r0_req = 0; r1_req = 0;
        next_cyc();
        next_cyc();

        chk("grants_outstanding", gq.size(), 32'd0);
        chk("reads_outstanding", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
